// File: rtl/alu_pipe_if.sv
// Handshake and result bus between operand fetch, the ALU and writeback.
// WIDTH must match the WIDTH of the alu_pipe instance it connects to.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_neg;
    logic             flag_ovf;
    logic             flag_err;
    logic             busy;

    // Producer of operations / consumer of results
    modport master (
        output in_valid, opcode, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry,
               flag_neg, flag_ovf, flag_err, busy
    );

    // The ALU itself
    modport slave (
        input  in_valid, opcode, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry,
               flag_neg, flag_ovf, flag_err, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags and an iterative shift-add
// multiplier. Single-cycle ops complete at the accept edge; MUL takes WIDTH
// cycles and blocks new operations while it runs.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] W_VAL    = (WIDTH + 1)'(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL1  = 4'd6;
    localparam logic [3:0] OP_SHR1  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_SLT   = 4'd11;
    localparam logic [3:0] OP_SLTU  = 4'd12;
    localparam logic [3:0] OP_MUL   = 4'd13;
    localparam logic [3:0] OP_PASSB = 4'd14;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    // Everything presented to writeback travels together
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
        logic             neg;
        logic             ovf;
        logic             err;
    } resp_t;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    resp_t            resp_q, resp_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             in_ready;
    logic             accept;
    logic             is_mul;
    resp_t            alu_resp;
    logic [WIDTH-1:0] mul_sum;

    wire [WIDTH-1:0] a = bus.operand_a;
    wire [WIDTH-1:0] b = bus.operand_b;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign is_mul   = MUL_EN && (bus.opcode == OP_MUL);

    // Single-cycle datapath: result and flags for the presented operation
    always_comb begin
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   diff;
        logic             sh_big;
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             err;
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        sh_big = ({1'b0, b} >= W_VAL);
        res    = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];  // borrow out == (A < B) unsigned
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_NOT:   res = ~a;
            OP_SHL1:  res = {a[WIDTH-2:0], 1'b0};
            OP_SHR1:  res = {1'b0, a[WIDTH-1:1]};
            OP_SLL:   res = sh_big ? '0 : (a << b);
            OP_SRL:   res = sh_big ? '0 : (a >> b);
            OP_SRA:   res = sh_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> b);
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_PASSB: res = b;
            // A legal MUL never takes this path; it is routed to the FSM
            OP_MUL:   err = !MUL_EN;
            default:  err = 1'b1;
        endcase
        alu_resp.result = res;
        alu_resp.zero   = (res == '0);
        alu_resp.carry  = carry;
        alu_resp.neg    = res[WIDTH-1];
        alu_resp.ovf    = ovf;
        alu_resp.err    = err;
    end

    // One shift-add step: accumulate the shifted multiplicand if the LSB is set
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next state: acceptance, multiply iteration and output-register handshake
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        resp_d      = resp_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d  = S_MUL;
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        resp_d      = alu_resp;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Output register was emptied when the MUL was accepted
                    state_d       = S_IDLE;
                    resp_d        = '0;
                    resp_d.result = mul_sum;
                    resp_d.zero   = (mul_sum == '0);
                    resp_d.neg    = mul_sum[WIDTH-1];
                    out_valid_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight multiply
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            resp_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            resp_q      <= resp_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = resp_q.result;
    assign bus.flag_zero  = resp_q.zero;
    assign bus.flag_carry = resp_q.carry;
    assign bus.flag_neg   = resp_q.neg;
    assign bus.flag_ovf   = resp_q.ovf;
    assign bus.flag_err   = resp_q.err;
    assign bus.busy       = (state_q == S_MUL);
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Width is generic, the opcode space grows to 4 bits, and the block adds:
  - variable shifts, signed and unsigned compares, and an iterative multi-cycle multiply;
  - status flags;
  - valid/ready flow control on both input and output, with a registered result.
- Sits between the decode/operand-fetch stage and writeback.

Parameters:
- WIDTH, 8: operand/result width in bits; legal values ≥ 2.
- MUL_EN, 1: when 1, opcode MUL is implemented; when 0, MUL is treated as illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- opcode  in  4  operation select.
- operand_a  in  WIDTH  operand A.
- operand_b  in  WIDTH  operand B; also the shift amount.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  ADD carry-out, or SUB borrow; 0 for all other opcodes.
- flag_neg  out  1  result[WIDTH-1].
- flag_ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.
- flag_err  out  1  illegal opcode.
- busy  out  1  multiply in progress.

Behaviour:
- Reset: all outputs are 0 on the cycle after a rising edge with rst=1, except in_ready, which is 1. The FSM goes to IDLE and any in-flight multiply is discarded.
- Single-cycle clock/reset domain; no clock gating.
- Acceptance: an operation is accepted on an edge where in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational; in_ready never depends on in_valid.
- Opcodes (A=operand_a, B=operand_b; all arithmetic is modulo 2^WIDTH):
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT: ~A.
  - 6 SHL1: A<<1.
  - 7 SHR1: logical A>>1.
  - 8 SLL: A<<B.
  - 9 SRL: logical A>>B.
  - 10 SRA: arithmetic A>>>B.
  - 11 SLT: 1 if A<B signed, else 0.
  - 12 SLTU: 1 if A<B unsigned, else 0.
  - 13 MUL: low WIDTH bits of A*B, unsigned.
  - 14 PASSB: B.
  - 15: illegal.
- Shift amount: B is taken as a full unsigned value. If B ≥ WIDTH, SLL/SRL give 0 and SRA gives all bits equal to A[WIDTH-1]. B = 0 passes A unchanged.
- Flags:
  - ADD: carry = carry-out of the WIDTH-bit add; ovf = A and B have the same sign and the result sign differs.
  - SUB: carry = borrow (A<B unsigned); ovf = A and B have different signs and the result sign differs from A.
  - zero and neg are computed from the final result for every opcode.
- Illegal opcode (15, or 13 with MUL_EN=0): result=0, flag_err=1, flag_zero=1, all other flags 0. Completes with single-cycle latency.
- Single-cycle opcodes: result and flags are loaded at the accept edge. out_valid=1 from the next cycle.
- FSM states and transitions:
  - IDLE → MUL on accepting opcode 13 (MUL_EN=1). At that edge, latch multiplicand=A and multiplier=B, clear the accumulator and the counter, and set busy=1.
  - MUL: runs exactly WIDTH cycles of shift-add, one multiplier bit per cycle, LSB first.
  - MUL → IDLE on the edge where the counter reaches WIDTH-1. On that edge, load result and flags (carry=0, ovf=0, err=0), set out_valid=1 and clear busy.
- Multiply latency: for a MUL accepted at edge T, out_valid rises at edge T+WIDTH. The output register is guaranteed empty at that point because acceptance required the output register to be empty or draining.
- Output register: result and flags hold stable while out_valid && !out_ready. out_valid clears on an edge with out_ready=1 unless a new operation is accepted on the same edge. A simultaneous drain and accept is allowed, giving back-to-back throughput of one op per cycle for single-cycle ops.
- in_valid while in_ready=0: ignored. The producer must hold the operation.
- rst asserted during MUL, or with out_valid=1: the result is discarded, and out_valid=0 and busy=0 on the next cycle.

Test Plan:
- WIDTH=8, ADD 0xFF+0x01 accepted at edge T → at T+1: out_valid=1, result=0x00, zero=1, carry=1, ovf=0, neg=0.
- SUB 0x80-0x01 → result 0x7F, ovf=1, carry=0. Then SUB 0x01-0x02 → 0xFF, carry=1, neg=1.
- Shifts and compares (WIDTH=8):
  - SRA 0x90 by 3 → 0xF2.
  - SRA 0x90 by 9 → 0xFF.
  - SRL 0x90 by 8 → 0x00, zero=1.
  - SLT 0x80 vs 0x01 → 1.
  - SLTU 0x80 vs 0x01 → 0.
- MUL 13×11 → result 0x8F, out_valid rising exactly 8 edges after acceptance. in_ready=0 and busy=1 throughout. MUL 0x10×0x10 → 0x00, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD → result stable, in_ready=0. With out_ready=1 and in_valid=1 continuously over 4 ADDs → 4 results on 4 consecutive cycles.
- Opcode 15 (and opcode 13 with MUL_EN=0) → result 0, flag_err=1. Asserting rst 3 cycles into a MUL → next cycle busy=0, out_valid=0, in_ready=1, and the result is never presented.
